// File: rtl/mux_rr_pipe_pkg.sv
// Shared constants and helpers for the mux_rr_pipe slice.
// Optional burst locking is enabled with the MUX_RR_PIPE_LOCK_EN macro.
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Index width for n channels, never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_rr_pipe_if.sv
// Producer/consumer bundle around mux_rr_pipe; slave is the mux view, master the driver view.
// in_last exists only when MUX_RR_PIPE_LOCK_EN is defined.
interface mux_rr_pipe_if
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN*WIDTH-1:0]   in_data;
    logic [NUM_IN-1:0]         in_ready;
`ifdef MUX_RR_PIPE_LOCK_EN
    logic [NUM_IN-1:0]         in_last;
`endif
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_src;
    logic                      out_ready;
    logic                      err_sel;

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
`ifdef MUX_RR_PIPE_LOCK_EN
        input  in_last,
`endif
        output in_ready, out_valid, out_data, out_src, err_sel
    );

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
`ifdef MUX_RR_PIPE_LOCK_EN
        output in_last,
`endif
        input  in_ready, out_valid, out_data, out_src, err_sel
    );

endinterface

// File: rtl/mux_rr_pipe_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping modulo NUM_IN.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_IN-1:0] grant_oh,
    output logic [SEL_W-1:0]  grant_idx
);

    int   idx;
    logic found;

    // Explicit wrap instead of a modulo keeps non-power-of-two NUM_IN cheap.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int off = 0; off < NUM_IN; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (!found && req[idx]) begin
                found         = 1'b1;
                grant_oh[idx] = 1'b1;
                grant_idx     = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_pipe.sv
// NUM_IN-to-1 valid/ready merge with select or round-robin choice and a registered output stage.
// Define MUX_RR_PIPE_LOCK_EN to hold round-robin grants across multi-beat bursts.
module mux_rr_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_rr_pipe_if.slave  bus
);

    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]  out_src_q, out_src_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              err_sel_q, err_sel_d;

    logic [NUM_IN-1:0] rr_req;
    logic [NUM_IN-1:0] rr_oh;
    logic [SEL_W-1:0]  rr_idx;
    logic [NUM_IN-1:0] sel_oh;
    logic [NUM_IN-1:0] grant_oh;
    logic [SEL_W-1:0]  grant_idx;
    logic              sel_in_range;
    logic              load_en;
    logic              xfer;
    logic              last_beat;

`ifdef MUX_RR_PIPE_LOCK_EN
    logic              lock_q, lock_d;
    logic [SEL_W-1:0]  lock_idx_q, lock_idx_d;

    // While locked, only the owning channel is offered to the arbiter.
    always_comb begin
        rr_req = bus.in_valid;
        if (lock_q) begin
            rr_req = bus.in_valid & (NUM_IN'(1) << lock_idx_q);
        end
    end
`else
    always_comb begin
        rr_req = bus.in_valid;
    end
`endif

    rr_arbiter #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .req       (rr_req),
        .ptr       (rr_ptr_q),
        .grant_oh  (rr_oh),
        .grant_idx (rr_idx)
    );

    // An out-of-range sel shifts the one-hot off the top, so it simply grants nothing.
    always_comb begin
        sel_in_range = int'(bus.sel) < NUM_IN;
        sel_oh       = bus.in_valid & (NUM_IN'(1) << bus.sel);
        load_en      = !out_valid_q || bus.out_ready;
        grant_oh     = (bus.mode == MODE_RR) ? rr_oh  : sel_oh;
        grant_idx    = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
        xfer         = rst_n && load_en && (|grant_oh);
`ifdef MUX_RR_PIPE_LOCK_EN
        last_beat    = |(bus.in_last & grant_oh);
`else
        last_beat    = 1'b1;
`endif
    end

    // Only round-robin transfers move the pointer; select-mode traffic leaves it alone.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        err_sel_d   = (bus.mode == MODE_SEL) && !sel_in_range && (|bus.in_valid);

        if (xfer && (bus.mode == MODE_RR) && last_beat) begin
            if (int'(grant_idx) == NUM_IN - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + SEL_W'(1);
            end
        end

        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
            out_src_d   = grant_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef MUX_RR_PIPE_LOCK_EN
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (bus.mode == MODE_SEL) begin
            lock_d = 1'b0;
        end else if (xfer) begin
            lock_d     = !last_beat;
            lock_idx_d = grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            err_sel_q   <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            err_sel_q   <= err_sel_d;
        end
    end

    assign bus.in_ready  = (rst_n && load_en) ? grant_oh : '0;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.err_sel   = err_sel_q;

endmodule

// File: tb/tb_mux_rr_pipe.sv
// Directed self-checking bench for mux_rr_pipe with a 4-input and a 3-input instance.
// Burst-lock vectors run only when MUX_RR_PIPE_LOCK_EN is defined.
module tb_mux_rr_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mux_rr_pipe_if #(.WIDTH(32), .NUM_IN(4)) bus4 ();
    mux_rr_pipe_if #(.WIDTH(32), .NUM_IN(3)) bus3 ();

    mux_rr_pipe #(.WIDTH(32), .NUM_IN(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    mux_rr_pipe #(.WIDTH(32), .NUM_IN(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
        bus4.mode      = m;
        bus4.sel       = s;
        bus4.in_valid  = v;
        bus4.out_ready = ordy;
        #1;
    endtask

    task automatic applyStimulus3(input logic m, input logic [1:0] s, input logic [2:0] v, input logic ordy);
        bus3.mode      = m;
        bus3.sel       = s;
        bus3.in_valid  = v;
        bus3.out_ready = ordy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setData4(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            bus4.in_data[i*32 +: 32] = base + 32'(i);
        end
    endtask

    initial begin
        int rr_seq[6];
        rr_seq = '{0, 1, 2, 3, 0, 1};

        rst_n = 1'b0;
        setData4(32'hA5A5_0000);
        for (int i = 0; i < 3; i++) begin
            bus3.in_data[i*32 +: 32] = 32'h3333_0000 + 32'(i);
        end
`ifdef MUX_RR_PIPE_LOCK_EN
        bus4.in_last = 4'b1111;
        bus3.in_last = 3'b111;
`endif
        applyStimulus(1'b0, 2'd0, 4'b1111, 1'b1);
        applyStimulus3(1'b0, 2'd0, 3'b111, 1'b1);
        tick();
        tick();

        checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("rst_out_data", bus4.out_data, 32'd0);
        checkOutput("rst_out_src", 32'(bus4.out_src), 32'd0);
        checkOutput("rst_in_ready", 32'(bus4.in_ready), 32'd0);
        checkOutput("rst_in_ready3", 32'(bus3.in_ready), 32'd0);
        checkOutput("rst_err_sel3", 32'(bus3.err_sel), 32'd0);

        // Select mode, channel 2.
        rst_n = 1'b1;
        applyStimulus3(1'b0, 2'd0, 3'b000, 1'b1);
        applyStimulus(1'b0, 2'd2, 4'b1111, 1'b1);
        checkOutput("sel_in_ready", 32'(bus4.in_ready), 32'b0100);
        tick();
        checkOutput("sel_out_valid", 32'(bus4.out_valid), 32'd1);
        checkOutput("sel_out_data", bus4.out_data, 32'hA5A5_0002);
        checkOutput("sel_out_src", 32'(bus4.out_src), 32'd2);

        // Round-robin over all four channels from pointer 0.
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("rr_in_ready", 32'(bus4.in_ready), 32'd1 << rr_seq[i]);
            tick();
            checkOutput("rr_out_src", 32'(bus4.out_src), 32'(rr_seq[i]));
            checkOutput("rr_out_data", bus4.out_data, 32'hA5A5_0000 + 32'(rr_seq[i]));
        end

        // Pointer now at 2; only channels 0 and 3 requesting.
        applyStimulus(1'b1, 2'd0, 4'b1001, 1'b1);
        checkOutput("rr_skip_ready3", 32'(bus4.in_ready), 32'b1000);
        tick();
        checkOutput("rr_skip_src3", 32'(bus4.out_src), 32'd3);
        checkOutput("rr_wrap_ready0", 32'(bus4.in_ready), 32'b0001);
        tick();
        checkOutput("rr_wrap_src0", 32'(bus4.out_src), 32'd0);

        // Backpressure: output holds channel 0 word for three cycles.
        setData4(32'hB0B0_0000);
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_in_ready", 32'(bus4.in_ready), 32'd0);
            tick();
            checkOutput("bp_out_valid", 32'(bus4.out_valid), 32'd1);
            checkOutput("bp_out_data", bus4.out_data, 32'hA5A5_0000);
            checkOutput("bp_out_src", 32'(bus4.out_src), 32'd0);
        end
        applyStimulus(1'b1, 2'd0, 4'b1111, 1'b1);
        checkOutput("bp_release_ready", 32'(bus4.in_ready), 32'b0010);
        tick();
        checkOutput("bp_release_data", bus4.out_data, 32'hB0B0_0001);
        checkOutput("bp_release_src", 32'(bus4.out_src), 32'd1);
        checkOutput("bp_release_valid", 32'(bus4.out_valid), 32'd1);

        // Drain without a new grant: valid drops, data is kept.
        applyStimulus(1'b1, 2'd0, 4'b0000, 1'b1);
        checkOutput("drain_in_ready", 32'(bus4.in_ready), 32'd0);
        tick();
        checkOutput("drain_out_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("drain_out_data", bus4.out_data, 32'hB0B0_0001);

        // Three-channel instance: out-of-range select.
        applyStimulus3(1'b0, 2'd3, 3'b111, 1'b1);
        checkOutput("err_in_ready3", 32'(bus3.in_ready), 32'd0);
        tick();
        checkOutput("err_sel_pulse", 32'(bus3.err_sel), 32'd1);
        checkOutput("err_out_valid3", 32'(bus3.out_valid), 32'd0);
        applyStimulus3(1'b0, 2'd3, 3'b000, 1'b1);
        tick();
        checkOutput("err_sel_clear", 32'(bus3.err_sel), 32'd0);

        // Only channel 2 valid: pointer wraps 2 -> 0 and channel 2 keeps winning.
        applyStimulus3(1'b1, 2'd0, 3'b100, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("wrap3_in_ready", 32'(bus3.in_ready), 32'b100);
            tick();
            checkOutput("wrap3_out_src", 32'(bus3.out_src), 32'd2);
            checkOutput("wrap3_out_data", bus3.out_data, 32'h3333_0002);
        end
        applyStimulus3(1'b1, 2'd0, 3'b111, 1'b1);
        checkOutput("wrap3_next_ready0", 32'(bus3.in_ready), 32'b001);
        tick();
        checkOutput("wrap3_next_src0", 32'(bus3.out_src), 32'd0);
        checkOutput("wrap3_next_ready1", 32'(bus3.in_ready), 32'b010);

`ifdef MUX_RR_PIPE_LOCK_EN
        // Fresh pointer, then move it to channel 1 with a single-beat transfer.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus4.in_last = 4'b1111;
        applyStimulus(1'b1, 2'd0, 4'b0001, 1'b1);
        tick();
        checkOutput("lock_pre_src", 32'(bus4.out_src), 32'd0);

        bus4.in_last = 4'b1101;
        applyStimulus(1'b1, 2'd0, 4'b0111, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checkOutput("lock_beat_ready", 32'(bus4.in_ready), 32'b0010);
            tick();
            checkOutput("lock_beat_src", 32'(bus4.out_src), 32'd1);
        end
        bus4.in_last = 4'b1111;
        #1;
        checkOutput("lock_last_ready", 32'(bus4.in_ready), 32'b0010);
        tick();
        checkOutput("lock_last_src", 32'(bus4.out_src), 32'd1);

        // Channel 2 starts a burst, then reset lands mid-burst.
        bus4.in_last = 4'b1011;
        #1;
        checkOutput("lock_next_ready", 32'(bus4.in_ready), 32'b0100);
        tick();
        checkOutput("lock_next_src", 32'(bus4.out_src), 32'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checkOutput("lock_rst_valid", 32'(bus4.out_valid), 32'd0);
        checkOutput("lock_rst_ready", 32'(bus4.in_ready), 32'b0001);
        tick();
        checkOutput("lock_rst_src", 32'(bus4.out_src), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_rr_pipe.md
Name: mux_rr_pipe

Overview:
- Parametrised successor to the team's fixed 4:1 single-bit select mux.
- Merges NUM_IN valid/ready source channels of WIDTH bits into one registered output channel.
- Two channel-choice modes: explicit select, or fair round-robin arbitration.
- Sits in the datapath where several producers share one consumer: writeback sources, operand forwarding, bus return data.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_W, $clog2(NUM_IN), select/index width; derived, do not override.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- mode  input  1  0 = select mode, 1 = round-robin mode; sampled every cycle.
- sel  input  SEL_W  channel index used in select mode.
- in_valid  input  NUM_IN  per-channel valid.
- in_data  input  NUM_IN*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  per-channel ready (combinational).
- out_valid  output  1  registered output valid.
- out_data  output  WIDTH  registered output data.
- out_src  output  SEL_W  index of the channel that produced out_data.
- out_ready  input  1  consumer ready.
- err_sel  output  1  registered one-cycle pulse: select mode with sel >= NUM_IN while any in_valid is set.

Behaviour:
- Reset (rst_n = 0 at a clock edge): out_valid = 0, out_data = 0, out_src = 0, rr_ptr = 0, err_sel = 0. Held output data is discarded. in_ready is 0 while rst_n = 0.
- load_en = !out_valid || out_ready. The output register accepts new data only when load_en = 1.
- Grant, select mode (mode = 0):
  - grant = sel if sel < NUM_IN and in_valid[sel] = 1; otherwise no grant.
  - Out-of-range sel: no transfer, and err_sel = 1 on the next cycle.
- Grant, round-robin mode (mode = 1):
  - grant = first i with in_valid[i] = 1, scanning rr_ptr, rr_ptr+1, ... and wrapping modulo NUM_IN.
  - After a transfer from channel k, rr_ptr <= (k+1) mod NUM_IN. With no transfer, rr_ptr is unchanged.
  - rr_ptr is retained across mode switches.
- in_ready[i] = load_en && grant valid && grant == i. At most one bit is set.
- Transfer occurs on in_valid[g] && in_ready[g]. Next cycle: out_valid = 1, out_data = channel g data, out_src = g.
- Output holds: if out_valid = 1 and out_ready = 0, out_data and out_src are held stable and all in_ready = 0.
- Drain: if out_ready = 1 and there is no grant, out_valid <= 0. out_data is not cleared.
- Drain and load in the same cycle: the new word replaces the old. Sustained throughput is 1 word/cycle; latency is 1 cycle from transfer to out_valid.
- Round-robin wrap: NUM_IN not a power of two must wrap cleanly, e.g. NUM_IN = 3: 2 -> 0.
- Mode or sel change while the output is stalled: takes effect on the next load only; held output is unaffected.
- in_valid dropping without a transfer is legal; no state changes.

Optional Feature:
- Macro MUX_RR_PIPE_LOCK_EN.
- Defined:
  - Adds input in_last [NUM_IN].
  - In round-robin mode, after a transfer from channel k with in_last[k] = 0, the arbiter locks onto k. Only k may be granted until a transfer with in_last[k] = 1; rr_ptr advances only on that transfer.
  - Switching to select mode clears the lock. Reset clears the lock.
- Undefined: no in_last port; every transfer is treated as last.

Decomposition:
- Shared package mux_pkg: MODE_SEL = 1'b0 and MODE_RR = 1'b1 constants, plus a clog2-style helper function for SEL_W.
- One natural sub-module: rr_arbiter (NUM_IN requests, pointer in, one-hot grant and index out; purely combinational).
- Pointer, lock and output registers stay in mux_rr_pipe.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, out_src = 0, in_ready = 0.
- Select mode, NUM_IN = 4, sel = 2, in_valid = 4'b1111, ch2 = 32'hA5A5_0002, out_ready = 1 -> in_ready = 4'b0100; next cycle out_data = 32'hA5A5_0002, out_src = 2.
- Round-robin, all 4 valid, out_ready = 1 for 6 cycles -> out_src sequence 0,1,2,3,0,1; then in_valid = 4'b1001 with rr_ptr = 2 -> next grant 3, then 0.
- Backpressure: out_valid = 1, out_ready = 0 for 3 cycles with new inputs valid -> out_data/out_src stable, in_ready = 0; out_ready = 1 -> next word loads in the same cycle the old one drains.
- NUM_IN = 3, select mode, sel = 3, in_valid = 3'b111 -> no in_ready; err_sel pulses 1 cycle. Round-robin with only ch2 valid repeatedly -> rr_ptr wraps to 0 and ch2 is still granted each cycle.
- With MUX_RR_PIPE_LOCK_EN: ch1 sends 3 beats (in_last = 0,0,1) while ch0 and ch2 are valid -> out_src = 1,1,1, then 2; rst_n = 0 mid-burst clears the lock and the next grant is ch0.
